alu4_arbiter: RTL and testbench

ALU4_ARBITER -- requirements
Module: alu4_arbiter

---
 rtl/alu4_arbiter_if.sv | 30 +++
 rtl/alu4_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_alu4_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu4_arbiter_if.sv
// Request/response bundle between two ALU requesters, the arbiter and the result consumer.
// The slave view belongs to the arbiter. The master view belongs to whoever drives requests and consumes results.
interface alu4_arbiter_if;
  logic [1:0] req_valid;
  logic [3:0] req_opcode0;
  logic [3:0] req_opcode1;
  logic [3:0] req_a0;
  logic [3:0] req_b0;
  logic [3:0] req_a1;
  logic [3:0] req_b1;
  logic [1:0] req_ready;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_out;
  logic       rsp_z;
  logic       rsp_c;
  logic       rsp_v;
  logic       busy;

  modport master (
    output req_valid, req_opcode0, req_opcode1, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_z, rsp_c, rsp_v, busy
  );

  modport slave (
    input  req_valid, req_opcode0, req_opcode1, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_out, rsp_z, rsp_c, rsp_v, busy
  );
endinterface

// File: rtl/alu4_arbiter.sv
// Two-requester, round-robin front end for a 4-bit ALU.
// Each operation takes one accept cycle (IDLE), one compute cycle (EXEC) and one or more response cycles (RESP).
// Operands are latched on the accept edge, so requesters are free to change their inputs while an operation is in flight.
module alu4_arbiter (
  input  logic          clk,
  input  logic          rst,
  alu4_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t     state;
  state_t     state_next;

  logic       last_grant;
  logic       grant_id;
  logic [1:0] grant_onehot;
  logic       accept;

  logic [3:0] op_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       id_q;

  logic [3:0] alu_out;
  logic       alu_c;
  logic       alu_v;
  logic [3:0] shr;
  logic [3:0] add_y;
  logic       add_cin;
  logic [3:0] add_low;
  logic [4:0] add_full;

  logic [3:0] out_q;
  logic       z_q;
  logic       c_q;
  logic       v_q;
  logic       rsp_id_q;

  // On a tie, pick the requester that was not served last; otherwise serve whoever is asking.
  always_comb begin
    grant_id = 1'b0;
    case (bus.req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

  // Next state, plus the one-hot ready, which can only be raised while waiting in IDLE.
  always_comb begin
    state_next   = state;
    grant_onehot = 2'b00;
    case (state)
      IDLE: begin
        if (bus.req_valid != 2'b00) begin
          grant_onehot = grant_id ? 2'b10 : 2'b01;
          state_next   = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Ready is masked by reset so that nothing looks accepted while the block is held in reset.
  assign bus.req_ready = rst ? 2'b00 : grant_onehot;
  assign accept        = (grant_onehot != 2'b00);

  // State register. An asynchronous reset drops any operation in flight straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the winner's opcode and operands on the accept edge, and remember the winner for round-robin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= 4'h0;
      a_q        <= 4'h0;
      b_q        <= 4'h0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      op_q       <= grant_id ? bus.req_opcode1 : bus.req_opcode0;
      a_q        <= grant_id ? bus.req_a1 : bus.req_a0;
      b_q        <= grant_id ? bus.req_b1 : bus.req_b0;
      id_q       <= grant_id;
      last_grant <= grant_id;
    end
  end

  // ALU datapath on the latched operands. The top two opcode bits select shift/arith/logic/compare.
  // All four arithmetic ops share one adder (A + Y + cin), and overflow is taken from its carries into and out of bit 3.
  always_comb begin
    alu_out  = 4'h0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    shr      = b_q >> a_q[1:0];
    add_y    = 4'h0;
    add_cin  = 1'b0;
    add_low  = 4'h0;
    add_full = 5'h00;
    case (op_q[3:2])
      2'b00: begin
        case (op_q[1:0])
          2'b00, 2'b01: alu_out = b_q << a_q[1:0];
          2'b10:        alu_out = shr;
          default:      alu_out = {b_q[3], shr[2:0]};
        endcase
      end
      2'b01: begin
        case (op_q[1:0])
          2'b00:   begin add_y = b_q;   add_cin = 1'b0; end
          2'b01:   begin add_y = 4'd1;  add_cin = 1'b0; end
          2'b10:   begin add_y = ~b_q;  add_cin = 1'b1; end
          default: begin add_y = ~4'd1; add_cin = 1'b1; end
        endcase
        add_low  = {1'b0, a_q[2:0]} + {1'b0, add_y[2:0]} + {3'b000, add_cin};
        add_full = {1'b0, a_q} + {1'b0, add_y} + {4'b0000, add_cin};
        alu_out  = add_full[3:0];
        alu_c    = add_full[4];
        alu_v    = add_low[3] ^ add_full[4];
      end
      2'b10: begin
        case (op_q[1:0])
          2'b00:   alu_out = a_q & b_q;
          2'b01:   alu_out = a_q | b_q;
          2'b10:   alu_out = a_q ^ b_q;
          default: alu_out = ~(a_q | b_q);
        endcase
      end
      default: begin
        case (op_q[1:0])
          2'b00:   alu_out = {3'b000, (a_q == b_q)};
          2'b01:   alu_out = {3'b000, (a_q != b_q)};
          2'b10:   alu_out = {3'b000, ($signed(a_q) > $signed(b_q))};
          default: alu_out = {3'b000, ($signed(a_q) < $signed(b_q))};
        endcase
      end
    endcase
  end

  // Register the result in EXEC. It then holds unchanged through RESP for as long as the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= 4'h0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      rsp_id_q <= 1'b0;
    end else if (state == EXEC) begin
      out_q    <= alu_out;
      z_q      <= (alu_out == 4'h0);
      c_q      <= alu_c;
      v_q      <= alu_v;
      rsp_id_q <= id_q;
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_out   = out_q;
  assign bus.rsp_z     = z_q;
  assign bus.rsp_c     = c_q;
  assign bus.rsp_v     = v_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu4_arbiter.sv
// Self-checking bench for alu4_arbiter.
// Directed scenarios plus randomized traffic are checked against an arithmetic reference model and a round-robin grant model.
module tb_alu4_arbiter;

  logic clk;
  logic rst;

  alu4_arbiter_if bus ();

  alu4_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checkCount     = 0;
  int passCount      = 0;
  int failCount      = 0;
  int lastGrant      = 1;
  int bothReadyCount = 0;

  logic [3:0] lastOut;
  logic       lastZ;
  logic       lastC;
  logic       lastV;
  logic       lastId;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ready must never be granted to both requesters in the same cycle.
  always @(negedge clk) begin
    if (bus.req_ready == 2'b11) bothReadyCount++;
  end

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  // Reference ALU built from signed/unsigned integer arithmetic. Returns {out[3:0], z, c, v}.
  function automatic logic [6:0] refAlu(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int ua, ub, sa, sb, r;
    logic [3:0] out;
    logic c, v;
    ua = a;
    ub = b;
    sa = a[3] ? ua - 16 : ua;
    sb = b[3] ? ub - 16 : ub;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (op)
      4'd0, 4'd1: r = ub << a[1:0];
      4'd2:       r = ub >> a[1:0];
      4'd3:       r = ((ub >> a[1:0]) % 8) + (b[3] ? 8 : 0);
      4'd4: begin r = ua + ub; c = (r > 15);   v = (sa + sb > 7) || (sa + sb < -8); end
      4'd5: begin r = ua + 1;  c = (r > 15);   v = (sa + 1 > 7); end
      4'd6: begin r = ua - ub; c = (ua >= ub); v = (sa - sb > 7) || (sa - sb < -8); end
      4'd7: begin r = ua - 1;  c = (ua >= 1);  v = (sa - 1 < -8); end
      4'd8:  r = ua & ub;
      4'd9:  r = ua | ub;
      4'd10: r = ua ^ ub;
      4'd11: r = 15 - (ua | ub);
      4'd12: r = (ua == ub) ? 1 : 0;
      4'd13: r = (ua != ub) ? 1 : 0;
      4'd14: r = (sa > sb) ? 1 : 0;
      default: r = (sa < sb) ? 1 : 0;
    endcase
    out = r[3:0];
    return {out, (out == 4'h0), c, v};
  endfunction

  // Present one request pattern, follow the winning operation to completion and check every phase.
  // Stall counts the RESP cycles for which rsp_ready is held low.
  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [3:0] op0, input logic [3:0] a0, input logic [3:0] b0,
                               input logic [3:0] op1, input logic [3:0] a1, input logic [3:0] b1,
                               input int stall);
    int grant;
    logic [1:0] expReady;
    logic [6:0] exp;
    bus.req_valid   = valid;
    bus.req_opcode0 = op0;
    bus.req_a0      = a0;
    bus.req_b0      = b0;
    bus.req_opcode1 = op1;
    bus.req_a1      = a1;
    bus.req_b1      = b1;
    bus.rsp_ready   = (stall == 0);
    if (valid == 2'b11)      grant = 1 - lastGrant;
    else if (valid == 2'b10) grant = 1;
    else                     grant = 0;
    expReady = (grant == 1) ? 2'b10 : 2'b01;
    exp = (grant == 1) ? refAlu(op1, a1, b1) : refAlu(op0, a0, b0);

    @(negedge clk);
    checkOutput("req_ready_idle", 8'(bus.req_ready), 8'(expReady));
    checkOutput("busy_idle", 8'(bus.busy), 8'd0);

    @(posedge clk);
    #1;
    lastGrant = grant;
    // Scramble the request inputs after the accept edge. The operation in flight must not notice.
    bus.req_opcode0 = 4'($urandom);
    bus.req_a0      = 4'($urandom);
    bus.req_b0      = 4'($urandom);
    bus.req_opcode1 = 4'($urandom);
    bus.req_a1      = 4'($urandom);
    bus.req_b1      = 4'($urandom);
    checkOutput("busy_exec", 8'(bus.busy), 8'd1);
    checkOutput("rsp_valid_exec", 8'(bus.rsp_valid), 8'd0);
    checkOutput("req_ready_exec", 8'(bus.req_ready), 8'd0);

    @(posedge clk);
    #1;
    lastOut = bus.rsp_out;
    lastZ   = bus.rsp_z;
    lastC   = bus.rsp_c;
    lastV   = bus.rsp_v;
    lastId  = bus.rsp_id;
    checkOutput("rsp_valid", 8'(bus.rsp_valid), 8'd1);
    checkOutput("rsp_id", 8'(bus.rsp_id), 8'(grant));
    checkOutput("rsp_out", 8'(bus.rsp_out), 8'(exp[6:3]));
    checkOutput("rsp_z", 8'(bus.rsp_z), 8'(exp[2]));
    checkOutput("rsp_c", 8'(bus.rsp_c), 8'(exp[1]));
    checkOutput("rsp_v", 8'(bus.rsp_v), 8'(exp[0]));

    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_rsp_valid", 8'(bus.rsp_valid), 8'd1);
      checkOutput("stall_fields", {bus.rsp_id, bus.rsp_out, bus.rsp_z, bus.rsp_c, bus.rsp_v},
                  {1'(grant), exp[6:3], exp[2], exp[1], exp[0]});
      checkOutput("stall_req_ready", 8'(bus.req_ready), 8'd0);
      checkOutput("stall_busy", 8'(bus.busy), 8'd1);
    end
    bus.rsp_ready = 1'b1;

    @(posedge clk);
    #1;
    checkOutput("busy_after_rsp", 8'(bus.busy), 8'd0);
    checkOutput("rsp_valid_after_rsp", 8'(bus.rsp_valid), 8'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, 8'(bus.req_ready), 8'd0);
    checkOutput({tag, "_fields"}, {bus.rsp_valid, bus.rsp_id, bus.rsp_out, bus.rsp_z, bus.rsp_c},
                8'd0);
    checkOutput({tag, "_v_busy"}, {6'd0, bus.rsp_v, bus.busy}, 8'd0);
  endtask

  initial begin
    logic [1:0] rv;
    logic [3:0] sweepA;
    logic [3:0] sweepB;
    rst             = 1'b1;
    bus.req_valid   = 2'b11;
    bus.req_opcode0 = 4'd4;
    bus.req_a0      = 4'd1;
    bus.req_b0      = 4'd1;
    bus.req_opcode1 = 4'd4;
    bus.req_a1      = 4'd2;
    bus.req_b1      = 4'd2;
    bus.rsp_ready   = 1'b1;

    // Everything held at zero while in reset, even with both requesters asking.
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    bus.req_valid = 2'b00;
    rst = 1'b0;
    lastGrant = 1;

    // No requests: the block stays idle.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle_busy", 8'(bus.busy), 8'd0);
    checkOutput("idle_req_ready", 8'(bus.req_ready), 8'd0);

    // Single add: 7 + 1 overflows into the sign bit.
    applyStimulus(2'b01, 4'd4, 4'd7, 4'd1, 4'd0, 4'd0, 4'd0, 0);
    checkOutput("add_out", 8'(lastOut), 8'd8);
    checkOutput("add_flags", {5'd0, lastZ, lastC, lastV}, 8'b0000_0001);
    checkOutput("add_id", 8'(lastId), 8'd0);

    // Subtract to zero: there is no borrow, so carry is set.
    applyStimulus(2'b10, 4'd0, 4'd0, 4'd0, 4'd6, 4'd5, 4'd5, 0);
    checkOutput("sub0_out", 8'(lastOut), 8'd0);
    checkOutput("sub0_flags", {5'd0, lastZ, lastC, lastV}, 8'b0000_0110);
    checkOutput("sub0_id", 8'(lastId), 8'd1);

    // Subtract with signed overflow: -8 - 1 wraps to 7.
    applyStimulus(2'b01, 4'd6, 4'd8, 4'd1, 4'd0, 4'd0, 4'd0, 0);
    checkOutput("subv_out", 8'(lastOut), 8'd7);
    checkOutput("subv_v", 8'(lastV), 8'd1);

    // Serve requester 1 once so that the next tie goes to requester 0, then alternate on six ties.
    applyStimulus(2'b10, 4'd9, 4'd1, 4'd2, 4'd9, 4'd3, 4'd4, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b11, 4'($urandom), 4'($urandom), 4'($urandom),
                    4'($urandom), 4'($urandom), 4'($urandom), 0);
      checkOutput("rr_order", 8'(lastId), 8'(i % 2));
    end

    // Consumer holds off for five cycles: the response must be frozen.
    applyStimulus(2'b01, 4'd10, 4'd12, 4'd5, 4'd0, 4'd0, 4'd0, 5);

    // Reset during EXEC: the operation vanishes, and requester 0 wins the next tie.
    bus.req_valid   = 2'b01;
    bus.req_opcode0 = 4'd4;
    bus.req_a0      = 4'd3;
    bus.req_b0      = 4'd3;
    bus.rsp_ready   = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("pre_reset_busy", 8'(bus.busy), 8'd1);
    bus.req_valid = 2'b11;
    rst = 1'b1;
    #1;
    checkResetOutputs("async_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_rsp_valid", 8'(bus.rsp_valid), 8'd0);
    end
    bus.req_valid = 2'b00;
    rst = 1'b0;
    lastGrant = 1;
    applyStimulus(2'b11, 4'd8, 4'd15, 4'd3, 4'd8, 4'd15, 4'd5, 0);
    checkOutput("post_reset_tie", 8'(lastId), 8'd0);

    // Sweep every opcode with A=1010, B=0110, alternating requesters.
    sweepA = 4'b1010;
    sweepB = 4'b0110;
    for (int op = 0; op < 16; op++) begin
      if (op % 2 == 0) applyStimulus(2'b01, 4'(op), sweepA, sweepB, 4'd0, 4'd0, 4'd0, 0);
      else             applyStimulus(2'b10, 4'd0, 4'd0, 4'd0, 4'(op), sweepA, sweepB, 0);
      // B >> 2 leaves 0001, and B[3]=0 keeps the top bit clear.
      if (op == 3)  checkOutput("sweep_op3", 8'(lastOut), 8'd1);
      if (op == 14) checkOutput("sweep_op14", 8'(lastOut), 8'd0);
      if (op == 15) checkOutput("sweep_op15", 8'(lastOut), 8'd1);
    end

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 40; i++) begin
      rv = 2'($urandom_range(1, 3));
      applyStimulus(rv, 4'($urandom), 4'($urandom), 4'($urandom),
                    4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 2));
    end

    bus.req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("never_both_ready", 8'(bothReadyCount), 8'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
